// File: rtl/ah_div_result_fifo.sv
// ah_div_result_fifo
// Captures every result from the pipelined divider into a small show-ahead
// FIFO and hands it to the consumer over a valid/ready handshake. A credit
// counter (stored + in-flight) tells the issuing logic when another divide
// may start without any chance of losing its result.
module ah_div_result_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           issue,
    output logic                           issue_ready,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_quotient,
    input  logic                           in_div_by_zero,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_quotient,
    output logic                           out_div_by_zero,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [$clog2(DEPTH+1)-1:0]     inflight,
    output logic                           overflow,
    output logic                           unexpected
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW:0]   CRED_LIM  = (CW+1)'(DEPTH);

    // Storage: each entry is {div_by_zero, quotient}
    logic [WIDTH:0]  r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_inflight;
    logic            r_overflow;
    logic            r_unexpected;

    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_issue_acc;
    logic            w_return;
    logic            w_stray;
    logic [CW:0]     w_credit_sum;
    logic [CW-1:0]   w_count_nxt;
    logic [CW-1:0]   w_inflight_nxt;
    logic [WIDTH:0]  w_head;

    // Handshake decode and credit availability (registered counters only)
    always_comb begin
        w_full       = (r_count == FULL_CNT);
        w_pop        = (r_count != '0) && out_ready;
        // A push into a full FIFO is only legal when the head leaves the same cycle
        w_push       = in_valid && (!w_full || w_pop);
        w_drop       = in_valid && !w_push;
        w_credit_sum = {1'b0, r_count} + {1'b0, r_inflight};
        issue_ready  = rst_n && (w_credit_sum < CRED_LIM);
        w_issue_acc  = issue && issue_ready;
        // A result with nothing outstanding leaves inflight saturated at zero
        w_return     = in_valid && (r_inflight != '0);
        w_stray      = in_valid && (r_inflight == '0);
    end

    // Next-state values for the occupancy and credit counters
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end

        w_inflight_nxt = r_inflight;
        if (w_issue_acc && !w_return) begin
            w_inflight_nxt = r_inflight + CW'(1);
        end else if (!w_issue_acc && w_return) begin
            w_inflight_nxt = r_inflight - CW'(1);
        end
    end

    // Result array write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_div_by_zero, in_quotient};
        end
    end

    // Pointers, counters and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_inflight   <= '0;
            r_overflow   <= 1'b0;
            r_unexpected <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_inflight <= w_inflight_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_stray) begin
                r_unexpected <= 1'b1;
            end
        end
    end

    // Show-ahead head presentation and status outputs
    always_comb begin
        w_head          = r_mem[r_rd_ptr];
        out_valid       = (r_count != '0);
        out_quotient    = w_head[WIDTH-1:0];
        out_div_by_zero = w_head[WIDTH];
        count           = r_count;
        inflight        = r_inflight;
        overflow        = r_overflow;
        unexpected      = r_unexpected;
    end

endmodule

// File: tb/tb_ah_div_result_fifo.sv
// Self-checking bench for ah_div_result_fifo: a directed vector table, hand
// sequences for full/overflow/reset corners, and a randomised run against a
// queue scoreboard with a fixed-latency divider stand-in.
module tb_ah_div_result_fifo;

    localparam int W  = 50;
    localparam int D  = 16;
    localparam int CW = $clog2(D+1);

    logic          clk;
    logic          rst_n;
    logic          issue;
    logic          issue_ready;
    logic          in_valid;
    logic [W-1:0]  in_quotient;
    logic          in_div_by_zero;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_quotient;
    logic          out_div_by_zero;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic          overflow;
    logic          unexpected;

    ah_div_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue          (issue),
        .issue_ready    (issue_ready),
        .in_valid       (in_valid),
        .in_quotient    (in_quotient),
        .in_div_by_zero (in_div_by_zero),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_quotient   (out_quotient),
        .out_div_by_zero(out_div_by_zero),
        .count          (count),
        .inflight       (inflight),
        .overflow       (overflow),
        .unexpected     (unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard model
    logic [W:0] sb[$];
    int         m_infl;
    bit         m_ovf;
    bit         m_unx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check);
        rst_n = 1'b0; issue = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_quotient = '0; in_div_by_zero = 1'b0;
        tick();
        if (check) begin
            chk("rst_count", count, 0);
            chk("rst_inflight", inflight, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_unexpected", unexpected, 0);
            chk("rst_issue_ready_low", issue_ready, 0);
        end
        rst_n = 1'b1;
        #1;
        if (check) chk("rst_issue_ready_rel", issue_ready, 1);
        sb.delete();
        m_infl = 0; m_ovf = 0; m_unx = 0;
    endtask

    // One clock of stimulus, checked against the scoreboard before and after the edge
    task automatic cyc(input bit iss, input bit iv, input logic [W-1:0] q,
                       input bit dz, input bit ordy);
        bit m_irdy, m_pop, m_push, m_ret;
        issue = iss; in_valid = iv; in_quotient = q; in_div_by_zero = dz; out_ready = ordy;
        #1;
        m_irdy = (sb.size() + m_infl) < D;
        m_pop  = (sb.size() != 0) && ordy;
        m_push = iv && ((sb.size() < D) || m_pop);
        m_ret  = iv && (m_infl != 0);
        chk("out_valid", out_valid, (sb.size() != 0));
        chk("issue_ready", issue_ready, m_irdy);
        if (sb.size() != 0) begin
            chk("head_quotient", out_quotient, sb[0][W-1:0]);
            chk("head_dbz", out_div_by_zero, sb[0][W]);
        end
        if (m_pop) void'(sb.pop_front());
        if (m_push) sb.push_back({dz, q});
        if (iv && !m_push) m_ovf = 1;
        if (iv && m_infl == 0) m_unx = 1;
        if (iss && m_irdy) m_infl++;
        if (m_ret) m_infl--;
        tick();
        chk("count", count, sb.size());
        chk("inflight", inflight, m_infl);
        chk("overflow", overflow, m_ovf);
        chk("unexpected", unexpected, m_unx);
    endtask

    typedef struct {
        bit         iss;
        bit         iv;
        logic [W-1:0] q;
        bit         dz;
        bit         ordy;
        int         e_cnt;
        int         e_infl;
        bit         e_ov;
        bit         chk_head;
        logic [W-1:0] e_q;
        bit         e_dz;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int acc;
        bit pipe[4];

        // iss iv  q                    dz ordy cnt infl ov hd  e_q                  e_dz
        tbl[0] = '{1, 0, 50'd0,               0, 0,  0,  1,  0, 0, 50'd0,               0};
        tbl[1] = '{1, 0, 50'd0,               0, 0,  0,  2,  0, 0, 50'd0,               0};
        tbl[2] = '{1, 0, 50'd0,               0, 0,  0,  3,  0, 0, 50'd0,               0};
        tbl[3] = '{0, 1, 50'd5,               0, 1,  1,  2,  1, 1, 50'd5,               0};
        tbl[4] = '{0, 1, 50'h3FFFF_FFFFFFFF,  1, 1,  1,  1,  1, 1, 50'h3FFFF_FFFFFFFF,  1};
        tbl[5] = '{0, 1, 50'd7,               0, 1,  1,  0,  1, 1, 50'd7,               0};
        tbl[6] = '{0, 0, 50'd0,               0, 1,  0,  0,  0, 0, 50'd0,               0};

        do_reset(0);
        do_reset(1);

        // Idle after reset
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 0);
        chk("idle_count", count, 0);
        chk("idle_issue_ready", issue_ready, 1);

        // Directed table: three issues, three returns drained in order
        for (int i = 0; i < 7; i++) begin
            issue = tbl[i].iss; in_valid = tbl[i].iv; in_quotient = tbl[i].q;
            in_div_by_zero = tbl[i].dz; out_ready = tbl[i].ordy;
            tick();
            chk("tbl_count", count, tbl[i].e_cnt);
            chk("tbl_inflight", inflight, tbl[i].e_infl);
            chk("tbl_out_valid", out_valid, tbl[i].e_ov);
            chk("tbl_issue_ready", issue_ready, 1);
            if (tbl[i].chk_head) begin
                chk("tbl_head_q", out_quotient, tbl[i].e_q);
                chk("tbl_head_dbz", out_div_by_zero, tbl[i].e_dz);
            end
        end
        chk("tbl_overflow", overflow, 0);
        chk("tbl_unexpected", unexpected, 0);

        // Fill credits with out_ready held low
        acc = 0;
        for (int i = 0; i < 40 && issue_ready; i++) begin
            cyc(1, 0, '0, 0, 0);
            acc++;
        end
        chk("fill_accepted", acc, 16);
        chk("fill_inflight", inflight, 16);
        chk("fill_issue_ready", issue_ready, 0);
        for (int i = 0; i < 16; i++) cyc(0, 1, W'(100 + i), i[0], 0);
        chk("full_count", count, 16);
        chk("full_inflight", inflight, 0);
        chk("full_issue_ready", issue_ready, 0);
        chk("full_overflow", overflow, 0);
        chk("full_head", out_quotient, 100);

        // One pop returns a credit the next cycle
        cyc(0, 0, '0, 0, 1);
        chk("pop_issue_ready", issue_ready, 1);
        chk("pop_count", count, 15);

        // Refill to 16 through a legitimate issue/return
        cyc(1, 0, '0, 0, 0);
        cyc(0, 1, W'(116), 0, 0);
        chk("refill_count", count, 16);
        chk("refill_unexpected", unexpected, 0);

        // Full with same-edge push and pop (nothing in flight, so also stray)
        cyc(0, 1, W'(200), 1, 1);
        chk("pushpop_count", count, 16);
        chk("pushpop_overflow", overflow, 0);
        chk("pushpop_unexpected", unexpected, 1);
        chk("pushpop_head", out_quotient, 102);

        // Full without pop: entry dropped
        cyc(0, 1, W'(300), 0, 0);
        chk("drop_overflow", overflow, 1);
        chk("drop_count", count, 16);

        // Drain; last entry must be 200, not the dropped 300
        for (int i = 0; i < 15; i++) cyc(0, 0, '0, 0, 1);
        chk("drain_last_q", out_quotient, 200);
        chk("drain_last_dbz", out_div_by_zero, 1);
        cyc(0, 0, '0, 0, 1);
        chk("drain_count", count, 0);

        // Reset mid-operation: 5 stored, 4 in flight
        do_reset(1);
        for (int i = 0; i < 9; i++) cyc(1, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, W'(i + 1), 0, 0);
        chk("mid_count", count, 5);
        chk("mid_inflight", inflight, 4);
        do_reset(1);

        // Result with nothing in flight after reset is flagged but kept
        cyc(0, 1, W'(42), 0, 0);
        chk("stray_unexpected", unexpected, 1);
        chk("stray_count", count, 1);
        chk("stray_inflight", inflight, 0);
        chk("stray_head", out_quotient, 42);
        do_reset(1);

        // Random traffic, upstream obeys issue_ready, divider latency of 4
        for (int i = 0; i < 4; i++) pipe[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            bit iss, iv, ordy;
            logic [W-1:0] q;
            iss  = ($urandom_range(0, 2) != 0) && issue_ready;
            iv   = pipe[3];
            pipe[3] = pipe[2]; pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = iss;
            ordy = ((c / 700) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                        : ($urandom_range(0, 4) == 0);
            q    = W'({$urandom(), $urandom()});
            cyc(iss, iv, q, 1'($urandom_range(0, 1)), ordy);
        end
        chk("rnd_overflow", overflow, 0);
        chk("rnd_unexpected", unexpected, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
